// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder, the only arithmetic element of the serial datapath.
// Ports:
//   in1, in2 : operand bits
//   cin      : carry in
//   sum      : in1 ^ in2 ^ cin
//   cout     : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, through a single full_adder instance.
// Timing: start sampled in IDLE at edge 0, bits processed at edges 1..WIDTH,
// done high for the one cycle after edge WIDTH, back in IDLE one edge later.
//
// Parameters:
//   WIDTH     : operand width, 2..32
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   start     : begin an addition (sampled only in IDLE)
//   a, b, cin : operands and carry-in, captured on the accepted start edge
//   busy      : high while the addition is in progress
//   done      : one-cycle completion pulse
//   sum, cout : result, cleared on an accepted start, final at edge WIDTH,
//               then held until the next accepted start
//   ovf       : (only with SERIAL_ADDER_OVF_EN) two's-complement overflow,
//               held with sum
// Build option:
//   SERIAL_ADDER_OVF_EN : adds the ovf output and its register
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    full_adder u_fa (
        .in1  (a_sh[0]),
        .in2  (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // ---------------------------------------------------------------- FSM --
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // ----------------------------------------------------------- datapath --
    // The partial result builds up in sum_sh; sum/cout are only written on
    // the final bit, so they stay at their cleared value throughout RUN.
    // NOTE: every datapath register, operands included, is reset so that an
    // aborted operation leaves no stale state behind.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        sum    <= '0;
                        cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= {fa_sum, sum_sh[WIDTH-1:1]};
                        cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry holds the carry into bit WIDTH-1 here.
                        ovf  <= carry ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). Stimulus tasks push the
// expected result into a queue; a monitor pops and compares on every done.
// Define SERIAL_ADDER_OVF_EN to also cover the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b1;
    logic         start     = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;
    int   pushed     = 0;
    int   cyc        = 0;
    int   start_cyc  = 0;

    serial_adder #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Monitor: one expectation consumed per done pulse.
    initial begin : monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (done) begin
                done_count++;
                check("done_pulse_width", 32'(prev_done), 0);
                check("done_has_expectation", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
            prev_done = done;
        end
    end

    // Wait for IDLE, present one operation for one edge, optionally expect it.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic push, input exp_t e);
        int guard;
        guard = 0;
        @(negedge sys_clk);
        while ((busy || done) && guard < 40) begin
            @(negedge sys_clk);
            guard++;
        end
        check("wait_idle", 32'(busy | done), 0);
        a     = ta;
        b     = tb_;
        cin   = tc;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            pushed++;
        end
        @(posedge sys_clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'b0;
    endtask

    // Follow an operation to its done cycle; returns busy cycle count and
    // whether sum/cout stayed cleared while busy.
    task automatic wait_done(output int busy_cycles, output logic clean);
        int guard;
        busy_cycles = 0;
        clean       = 1'b1;
        guard       = 0;
        @(negedge sys_clk);
        while (!done && guard < 20) begin
            if (busy) begin
                busy_cycles++;
                if (sum != '0 || cout != 1'b0) clean = 1'b0;
            end
            @(negedge sys_clk);
            guard++;
        end
        check("done_seen", 32'(done), 1);
        check("done_latency", cyc - start_cyc, W);
    endtask

    initial begin : stim
        int   bc;
        logic clean;
        int   s1;
        int   guard;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rs;

        // Reset asserted before any clock edge: outputs clear asynchronously.
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 0x0F + 0x01 + 0 = 0x010
        issue(8'h0F, 8'h01, 1'b0, 1'b1, mk(8'h10, 1'b0, 1'b0));
        wait_done(bc, clean);
        check("busy_cycles_1", bc, W);
        check("sum_stable_in_run_1", 32'(clean), 1);
        repeat (3) @(negedge sys_clk);
        check("sum_held", 32'(sum), 'h10);
        check("idle_after_done", 32'({busy, done}), 0);

        // 0xFF + 0x00 + 1 = 0x100, then back-to-back 0xFF + 0x01 = 0x100
        issue(8'hFF, 8'h00, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b0));
        wait_done(bc, clean);
        s1 = start_cyc;
        issue(8'hFF, 8'h01, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0));
        check("back_to_back_spacing", start_cyc - s1, W + 2);
        wait_done(bc, clean);
        check("busy_cycles_2", bc, W);

        // Second start during RUN is ignored: 0x3C + 0x05 = 0x041
        issue(8'h3C, 8'h05, 1'b0, 1'b1, mk(8'h41, 1'b0, 1'b0));
        repeat (2) @(negedge sys_clk);
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done(bc, clean);
        check("sum_stable_in_run_3", 32'(clean), 1);
        check("sum_held_before_abort", 32'(sum), 'h41);

        // Reset mid-RUN: immediate clear, no done; then 0x12 + 0x34 = 0x46
        issue(8'h55, 8'h22, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0));
        repeat (3) @(negedge sys_clk);
        check("busy_before_abort", 32'(busy), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", 32'(ovf), 0);
`endif
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        issue(8'h12, 8'h34, 1'b0, 1'b1, mk(8'h46, 1'b0, 1'b0));
        wait_done(bc, clean);
        check("busy_cycles_after_reset", bc, W);

`ifdef SERIAL_ADDER_OVF_EN
        // Signed overflow cases
        issue(8'h7F, 8'h01, 1'b0, 1'b1, mk(8'h80, 1'b0, 1'b1));
        wait_done(bc, clean);
        issue(8'h80, 8'h80, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b1));
        wait_done(bc, clean);
`endif

        // Random operands against an arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            issue(ra, rb, rc, 1'b1,
                  mk(rs[W-1:0], rs[W], (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1])));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge sys_clk);
            guard++;
        end
        repeat (2) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_count, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port sys_clk, input, 1 bit, the single system clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, the unsigned operands captured on the start edge.
REQ-006 The block SHALL have port cin, input, 1 bit, the carry-in captured on the start edge.
REQ-007 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have port sum, output, WIDTH bits, the result, held stable from done until the next accepted start.
REQ-010 The block SHALL have port cout, output, 1 bit, the final carry-out, held with sum.

Function
REQ-011 The block SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at an edge (edge 0), the block SHALL load a and b into shift registers, set the carry flop to cin, clear the bit counter and enter RUN.
REQ-013 In RUN, each edge SHALL add the LSBs of the a and b registers plus the carry flop, shift the sum bit into the MSB of the sum register, store the carry-out in the carry flop, and shift the a and b registers right by one.
REQ-014 The block SHALL leave RUN at edge WIDTH, after bits 0..WIDTH-1 have been processed, and enter DONE with sum and cout final.
REQ-015 The block SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE at the next edge.
REQ-016 Total latency SHALL be fixed: done is high in the cycle after edge WIDTH, counted from the start-sampling edge 0.
REQ-017 The block SHALL ignore start while in RUN or DONE, with no queuing and no effect on the current operation.
REQ-018 The block SHALL accept start in the cycle after DONE (back-to-back operation), giving a throughput of one addition per WIDTH+2 cycles.
REQ-019 The result SHALL equal {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1), with no saturation.
REQ-020 The sum and cout outputs SHALL not change during RUN until they become final at edge WIDTH; sum is the registered shift contents, and the previous result is not visible mid-operation.

Reset
REQ-021 sys_rst_n=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and clear busy, done, sum, cout, the counter, the operand registers and the carry flop to 0.
REQ-022 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL behave normally.

Configuration
REQ-023 When macro SERIAL_ADDER_OVF_EN is defined, the block SHALL add an output port ovf (1 bit) equal to the carry into bit WIDTH-1 XOR cout, i.e. two's-complement overflow.
REQ-024 ovf SHALL be registered at edge WIDTH, held with sum, and reset to 0.
REQ-025 When SERIAL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent.

Structure
REQ-026 Shared package serial_adder_pkg SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 The per-bit addition SHALL be performed by one instance of the existing full_adder sub-module (ports in1, in2, cin, sum, cout); there SHALL be no other arithmetic on the datapath.
REQ-028 The bit counter SHALL be sized with $clog2(WIDTH) bits.

Verification
REQ-029 Scenario: WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, done high exactly in the cycle after edge 8, busy high for 8 cycles.
REQ-030 Scenario: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; then back-to-back a=0xFF, b=0x01 -> sum=0x00, cout=1.
REQ-031 Scenario: start pulsed again at RUN cycle 3 with different operands -> ignored; result equals the first operands only.
REQ-032 Scenario: sys_rst_n pulled low at RUN cycle 4 -> all outputs 0 immediately, no done pulse; the next start of 0x12+0x34 -> 0x46.
REQ-033 Scenario (SERIAL_ADDER_OVF_EN): a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.
REQ-034 Scenario: 1000 random {a,b,cin} -> {cout,sum} matches the reference model a+b+cin on every done, and done count equals accepted starts.
